// File: rtl/ibuffer_issue_sched_if.sv
// Decode/issue side bundle of the instruction-buffer issue scheduler.
// slave is the scheduler; master is whoever drives decode and issue.
interface ibuffer_issue_sched_if #(
    parameter int NUM_WARPS = 4
);
    localparam int NW_BITS = $clog2(NUM_WARPS);

    logic                 enq_valid;
    logic [NW_BITS-1:0]   enq_wid;
    logic                 enq_ready;
    logic [NUM_WARPS-1:0] full_mask;
    logic [NUM_WARPS-1:0] stall_mask;
    logic                 issue_valid;
    logic [NW_BITS-1:0]   issue_wid;
    logic [NW_BITS-1:0]   issue_wid_n;
    logic                 issue_ready;
    logic                 empty;

    modport slave (
        input  enq_valid, enq_wid, stall_mask, issue_ready,
        output enq_ready, full_mask, issue_valid, issue_wid, issue_wid_n, empty
    );

    modport master (
        output enq_valid, enq_wid, stall_mask, issue_ready,
        input  enq_ready, full_mask, issue_valid, issue_wid, issue_wid_n, empty
    );
endinterface

// File: rtl/ibuffer_issue_sched.sv
// Per-warp instruction-buffer occupancy tracking plus round-robin issue selection.
// Handshakes (enq and issue) are valid/ready: a transfer happens on a clock edge where both are high.
module ibuffer_issue_sched #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ibuffer_issue_sched_if.slave  sif
);
    localparam int NW_BITS = $clog2(NUM_WARPS);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0]     r_cnt [NUM_WARPS];
    logic                 r_issue_valid;
    logic [NW_BITS-1:0]   r_issue_wid;
    logic [NW_BITS-1:0]   r_rr_ptr;

    logic [NUM_WARPS-1:0] w_full_mask;
    logic [NUM_WARPS-1:0] w_elig;
    logic                 w_enq_ready;
    logic                 w_enq_fire;
    logic                 w_fire;
    logic                 w_load;
    logic                 w_any;
    logic [NW_BITS-1:0]   w_sel;
    logic                 w_empty;

    assign w_fire      = r_issue_valid & sif.issue_ready;
    assign w_load      = ~r_issue_valid | sif.issue_ready;
    assign w_enq_ready = ~w_full_mask[sif.enq_wid];
    assign w_enq_fire  = sif.enq_valid & w_enq_ready;

    // The entry leaving this cycle is removed before judging eligibility; no enq bypass.
    always_comb begin
        w_full_mask = '0;
        w_elig      = '0;
        w_empty     = 1'b1;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_full_mask[w] = (r_cnt[w] == FULL_CNT);
            w_elig[w]      = ((r_cnt[w] - CNT_W'(w_fire && (r_issue_wid == NW_BITS'(w)))) != '0)
                             && !sif.stall_mask[w];
            if (r_cnt[w] != '0) w_empty = 1'b0;
        end
    end

    // Search starts one past the last pick; the NUM_WARPS step wraps back to r_rr_ptr itself.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_rr_ptr;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            if (!w_any && w_elig[r_rr_ptr + NW_BITS'(i)]) begin
                w_any = 1'b1;
                w_sel = r_rr_ptr + NW_BITS'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) r_cnt[w] <= '0;
            r_issue_valid <= 1'b0;
            r_issue_wid   <= '0;
            r_rr_ptr      <= NW_BITS'(NUM_WARPS - 1);
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                case ({w_enq_fire && (sif.enq_wid == NW_BITS'(w)),
                       w_fire && (r_issue_wid == NW_BITS'(w))})
                    2'b10:   r_cnt[w] <= r_cnt[w] + CNT_W'(1);
                    2'b01:   r_cnt[w] <= r_cnt[w] - CNT_W'(1);
                    default: r_cnt[w] <= r_cnt[w];
                endcase
            end
            if (w_load) begin
                if (w_any) begin
                    r_issue_valid <= 1'b1;
                    r_issue_wid   <= w_sel;
                    r_rr_ptr      <= w_sel;
                end else begin
                    r_issue_valid <= 1'b0;
                end
            end
        end
    end

    assign sif.enq_ready   = w_enq_ready;
    assign sif.full_mask   = w_full_mask;
    assign sif.issue_valid = r_issue_valid;
    assign sif.issue_wid   = r_issue_wid;
    assign sif.issue_wid_n = (w_load && w_any) ? w_sel : r_issue_wid;
    assign sif.empty       = w_empty;

    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(w_fire && (r_cnt[r_issue_wid] == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_enq_fire && (r_cnt[sif.enq_wid] == FULL_CNT)));
    a_issue_stable: assert property (@(posedge clk) disable iff (reset)
        (r_issue_valid && !sif.issue_ready) |=> (r_issue_valid && $stable(r_issue_wid)));
endmodule

// File: tb/tb_ibuffer_issue_sched.sv
// Directed bench for ibuffer_issue_sched: queue-count/round-robin reference model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_ibuffer_issue_sched;
    localparam int NUM_WARPS = 4;
    localparam int DEPTH     = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ibuffer_issue_sched_if #(.NUM_WARPS(NUM_WARPS)) bus ();

    ibuffer_issue_sched #(.NUM_WARPS(NUM_WARPS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-warp instruction counts, the held pick, and the last granted warp.
    int m_cnt [NUM_WARPS];
    bit m_valid;
    int m_wid;
    int m_last;
    bit model_ok = 1'b0;

    function automatic int pick(input logic [NUM_WARPS-1:0] stall, input bit fire);
        for (int k = 1; k <= NUM_WARPS; k++) begin
            int w;
            int left;
            w = (m_last + k) % NUM_WARPS;
            left = m_cnt[w] - ((fire && w == m_wid) ? 1 : 0);
            if (left > 0 && !stall[w]) return w;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) m_cnt[w] = 0;
            m_valid  = 1'b0;
            m_wid    = 0;
            m_last   = NUM_WARPS - 1;
            model_ok = 1'b1;
        end else if (model_ok) begin
            bit fire;
            bit load;
            int s;
            fire = m_valid && bus.issue_ready;
            load = !m_valid || bus.issue_ready;
            s    = pick(bus.stall_mask, fire);
            if (bus.enq_valid && m_cnt[bus.enq_wid] < DEPTH) m_cnt[bus.enq_wid]++;
            if (fire) m_cnt[m_wid]--;
            if (load) begin
                if (s >= 0) begin
                    m_valid = 1'b1;
                    m_wid   = s;
                    m_last  = s;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic [NUM_WARPS-1:0] exp_full;
            bit exp_empty;
            exp_full  = '0;
            exp_empty = 1'b1;
            for (int w = 0; w < NUM_WARPS; w++) begin
                exp_full[w] = (m_cnt[w] == DEPTH);
                if (m_cnt[w] != 0) exp_empty = 1'b0;
            end
            check("issue_valid", 32'(bus.issue_valid), 32'(m_valid));
            check("issue_wid", 32'(bus.issue_wid), 32'(m_wid));
            check("full_mask", 32'(bus.full_mask), 32'(exp_full));
            check("empty", 32'(bus.empty), 32'(exp_empty));
            check("enq_ready", 32'(bus.enq_ready), 32'(m_cnt[bus.enq_wid] < DEPTH));
            if (!reset) begin
                bit fire;
                int s;
                int exp_n;
                fire  = m_valid && bus.issue_ready;
                s     = pick(bus.stall_mask, fire);
                exp_n = ((!m_valid || bus.issue_ready) && s >= 0) ? s : m_wid;
                check("issue_wid_n", 32'(bus.issue_wid_n), 32'(exp_n));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input int w);
        bus.enq_valid = 1'b1;
        bus.enq_wid   = 2'(w);
    endtask

    task automatic enq_off();
        bus.enq_valid = 1'b0;
        bus.enq_wid   = '0;
    endtask

    int seq4 [7] = '{1, 2, 3, 0, 1, 2, 3};

    initial begin
        reset           = 1'b1;
        bus.enq_valid   = 1'b0;
        bus.enq_wid     = '0;
        bus.stall_mask  = '0;
        bus.issue_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(bus.issue_valid), 32'd0);
        check("rst_full", 32'(bus.full_mask), 32'h0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_enq_ready", 32'(bus.enq_ready), 32'd1);

        // Enqueue w0,w1,w2 with issue always ready
        reset = 1'b0;
        bus.issue_ready = 1'b1;
        enq(0); tick();
        enq(1); tick();
        check("s2_valid_rise", 32'(bus.issue_valid), 32'd1);
        check("s2_wid0", 32'(bus.issue_wid), 32'd0);
        enq(2); tick();
        check("s2_wid1", 32'(bus.issue_wid), 32'd1);
        enq_off(); tick();
        check("s2_wid2", 32'(bus.issue_wid), 32'd2);
        tick();
        check("s2_valid_drop", 32'(bus.issue_valid), 32'd0);
        check("s2_empty", 32'(bus.empty), 32'd1);

        // Fill w1 while issue is blocked; held pick survives a stall
        bus.issue_ready = 1'b0;
        enq(1); tick();
        enq(1); tick();
        check("s3_enq_ready_full", 32'(bus.enq_ready), 32'd0);
        check("s3_full_mask", 32'(bus.full_mask), 32'h2);
        tick();
        check("s3_full_after_drop", 32'(bus.full_mask), 32'h2);
        enq_off();
        bus.stall_mask = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s3_held_valid", 32'(bus.issue_valid), 32'd1);
            check("s3_held_wid", 32'(bus.issue_wid), 32'd1);
        end
        bus.stall_mask  = '0;
        bus.issue_ready = 1'b1;
        tick();
        tick();
        check("s3_drained", 32'(bus.empty), 32'd1);

        // All warps full, round-robin drain
        reset = 1'b1;
        bus.issue_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            enq(w); tick();
            enq(w); tick();
        end
        enq_off();
        check("s4_full_all", 32'(bus.full_mask), 32'hf);
        check("s4_first_wid", 32'(bus.issue_wid), 32'd0);
        bus.issue_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check("s4_rr_wid", 32'(bus.issue_wid), 32'(seq4[k]));
        end
        tick();
        check("s4_valid_end", 32'(bus.issue_valid), 32'd0);
        check("s4_empty", 32'(bus.empty), 32'd1);

        // Stalled w0 is skipped, then issues once the stall clears
        bus.stall_mask = 4'b0001;
        enq(0); tick();
        enq(1); tick();
        enq_off(); tick();
        check("s5_w1_issues", 32'(bus.issue_wid), 32'd1);
        check("s5_w1_valid", 32'(bus.issue_valid), 32'd1);
        tick();
        check("s5_w0_blocked", 32'(bus.issue_valid), 32'd0);
        bus.stall_mask = '0;
        tick();
        check("s5_w0_issues", 32'(bus.issue_wid), 32'd0);
        check("s5_w0_valid", 32'(bus.issue_valid), 32'd1);
        tick();

        // Fire and enqueue on w2 in the same cycle, then reset mid-burst
        enq(2); tick();
        enq_off(); tick();
        check("s6_w2_picked", 32'(bus.issue_wid), 32'd2);
        enq(2); tick();
        enq_off();
        check("s6_cnt_kept", 32'(bus.empty), 32'd0);
        check("s6_gap", 32'(bus.issue_valid), 32'd0);
        tick();
        check("s6_reissue_valid", 32'(bus.issue_valid), 32'd1);
        check("s6_reissue_wid", 32'(bus.issue_wid), 32'd2);
        bus.issue_ready = 1'b0;
        enq(3); tick();
        reset = 1'b1;
        tick();
        check("s6_rst_valid", 32'(bus.issue_valid), 32'd0);
        check("s6_rst_empty", 32'(bus.empty), 32'd1);
        reset = 1'b0;
        enq_off();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
